// File: rtl/tdoa_xcorr.sv
// Time-difference-of-arrival estimator for one microphone pair.
// Captures N sample pairs, then sweeps lags -MAXLAG..+MAXLAG computing the
// time-domain cross-correlation C(L) = sum_i A[i]*B[i+L], one MAC per cycle.
// Reports the lag with the largest C(L); ties keep the most negative lag.
//
// Handshake: a pair transfers on a rising clk edge where in_valid && in_ready.
// in_ready is high only in FILL and does not depend on in_valid; in_valid may
// drop for any number of cycles and is ignored whenever in_ready is low.
module tdoa_xcorr #(
    parameter int N      = 256,
    parameter int DW     = 14,
    parameter int MAXLAG = 16,
    parameter int ACCW   = 2*DW + $clog2(N)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic                         in_valid,
    input  logic signed [DW-1:0]         in_a,
    input  logic signed [DW-1:0]         in_b,
    output logic                         in_ready,
    output logic                         done,
    output logic [$clog2(MAXLAG)+1:0]    lag,
    output logic [ACCW-1:0]              peak,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    localparam int AW = $clog2(N);
    localparam int LW = $clog2(MAXLAG) + 2;
    localparam int PW = AW + 2;
    localparam logic signed [LW-1:0] LAG_MIN  = LW'(-MAXLAG);
    localparam logic signed [LW-1:0] LAG_MAX  = LW'(MAXLAG);
    localparam logic [AW-1:0]        IDX_LAST = AW'(N-1);
    localparam logic [AW:0]          WR_LAST  = (AW+1)'(N-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_CORR = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // sample buffers (simple dual port, registered read)
    logic signed [DW-1:0] mem_a [N];
    logic signed [DW-1:0] mem_b [N];
    logic signed [DW-1:0] rd_a_q, rd_b_q;

    // fill / sweep counters
    logic [AW:0]          wr_idx_q;
    logic [AW-1:0]        idx_q;
    logic signed [LW-1:0] lag_cnt_q;
    logic                 issue_q;

    // pipeline tags and datapath
    logic                   s1_valid_q, s1_inr_q, s1_first_q, s1_last_q;
    logic signed [LW-1:0]   s1_lag_q;
    logic                   s2_valid_q, s2_first_q, s2_last_q;
    logic signed [LW-1:0]   s2_lag_q;
    logic signed [2*DW-1:0] prod_q;
    logic                   s3_last_q;
    logic signed [LW-1:0]   s3_lag_q;
    logic signed [ACCW-1:0] acc_q;

    // running best and registered outputs
    logic signed [ACCW-1:0] best_peak_q;
    logic signed [LW-1:0]   best_lag_q;
    logic                   done_q, done_d;
    logic signed [LW-1:0]   lag_q, lag_d;
    logic signed [ACCW-1:0] peak_q, peak_d;

    logic                 wr_en;
    logic                 cmp_en;
    logic                 cmp_final;
    logic signed [PW-1:0] b_pos;
    logic                 b_inr;

    assign wr_en     = (state_q == S_FILL) && in_valid;
    assign cmp_en    = s3_last_q;
    assign cmp_final = s3_last_q && (s3_lag_q == LAG_MAX);

    assign in_ready  = (state_q == S_FILL);
    assign busy      = (state_q == S_FILL) || (state_q == S_CORR);
    assign done      = done_q;
    assign lag       = lag_q;
    assign peak      = peak_q;
    assign dbg_state = state_q;

    // B read position for the current (i, L) and whether it lands inside the window
    always_comb begin
        b_pos = PW'(lag_cnt_q) + PW'($signed({1'b0, idx_q}));
        b_inr = !b_pos[PW-1] && (b_pos < PW'(N));
    end

    // buffer write during FILL, registered read during CORR
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_a[wr_idx_q[AW-1:0]] <= in_a;
            mem_b[wr_idx_q[AW-1:0]] <= in_b;
        end
        rd_a_q <= mem_a[idx_q];
        rd_b_q <= mem_b[b_pos[AW-1:0]];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and output register next values
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        lag_d   = lag_q;
        peak_d  = peak_q;
        unique case (state_q)
            S_IDLE: if (go) state_d = S_FILL;
            S_FILL: if (in_valid && (wr_idx_q == WR_LAST)) state_d = S_CORR;
            S_CORR: if (cmp_final) state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                lag_d   = best_lag_q;
                peak_d  = best_peak_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // write index and lag/index sweep counters
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_q  <= '0;
            idx_q     <= '0;
            lag_cnt_q <= LAG_MIN;
            issue_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && go) wr_idx_q <= '0;
            else if (wr_en)              wr_idx_q <= wr_idx_q + (AW+1)'(1);

            if (state_q == S_FILL && state_d == S_CORR) begin
                idx_q     <= '0;
                lag_cnt_q <= LAG_MIN;
                issue_q   <= 1'b1;
            end else if (issue_q) begin
                if (idx_q == IDX_LAST) begin
                    idx_q <= '0;
                    if (lag_cnt_q == LAG_MAX) issue_q   <= 1'b0;
                    else                      lag_cnt_q <= lag_cnt_q + LW'(1);
                end else begin
                    idx_q <= idx_q + AW'(1);
                end
            end
        end
    end

    // MAC pipeline: read tag, product, accumulate (load on first term of a lag)
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_inr_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_lag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_lag_q   <= '0;
            prod_q     <= '0;
            s3_last_q  <= 1'b0;
            s3_lag_q   <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= issue_q;
            s1_inr_q   <= b_inr;
            s1_first_q <= (idx_q == '0);
            s1_last_q  <= (idx_q == IDX_LAST);
            s1_lag_q   <= lag_cnt_q;

            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_lag_q   <= s1_lag_q;
            prod_q     <= s1_inr_q ? (2*DW)'(rd_a_q) * (2*DW)'(rd_b_q) : '0;

            s3_last_q  <= s2_valid_q && s2_last_q;
            s3_lag_q   <= s2_lag_q;
            if (s2_valid_q) begin
                if (s2_first_q) acc_q <= ACCW'(prod_q);
                else            acc_q <= acc_q + ACCW'(prod_q);
            end
        end
    end

    // best-lag tracking: first lag seeds, later lags replace only if strictly greater
    always_ff @(posedge clk) begin
        if (reset) begin
            best_peak_q <= '0;
            best_lag_q  <= '0;
        end else if (cmp_en) begin
            if ((s3_lag_q == LAG_MIN) || (acc_q > best_peak_q)) begin
                best_peak_q <= acc_q;
                best_lag_q  <= s3_lag_q;
            end
        end
    end

    // result registers, updated on the done edge and held until the next result
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            lag_q  <= '0;
            peak_q <= '0;
        end else begin
            done_q <= done_d;
            lag_q  <= lag_d;
            peak_q <= peak_d;
        end
    end

endmodule

// File: tb/tb_tdoa_xcorr.sv
// Self-checking bench for tdoa_xcorr: reference correlation model feeds an
// expected-result queue; each scenario task checks its own observations.
module tb_tdoa_xcorr;

    localparam int N       = 256;
    localparam int DW      = 14;
    localparam int MAXLAG  = 16;
    localparam int ACCW    = 36;
    localparam int LW      = 6;
    localparam int W       = LW + ACCW;
    localparam int LATENCY = (2*MAXLAG+1)*N + 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   go;
    logic                   in_valid;
    logic signed [DW-1:0]   in_a, in_b;
    logic                   in_ready, done, busy;
    logic [LW-1:0]          lag;
    logic [ACCW-1:0]        peak;
    logic [1:0]             dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic signed [DW-1:0] wa [N];
    logic signed [DW-1:0] wb [N];
    logic signed [DW-1:0] ra [N];

    tdoa_xcorr #(.N(N), .DW(DW), .MAXLAG(MAXLAG), .ACCW(ACCW)) dut (
        .clk(clk), .reset(reset), .go(go), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .done(done),
        .lag(lag), .peak(peak), .busy(busy), .dbg_state(dbg_state)
    );

    // clock
    always #10 clk = ~clk;

    // reference: direct sum over all lags, strict-greater best with first-lag seed
    function automatic logic [W-1:0] model();
        longint c;
        longint best = 0;
        int     best_l = -MAXLAG;
        for (int l = -MAXLAG; l <= MAXLAG; l++) begin
            c = 0;
            for (int i = 0; i < N; i++)
                if (i + l >= 0 && i + l < N)
                    c += longint'(wa[i]) * longint'(wb[i+l]);
            if (l == -MAXLAG || c > best) begin
                best   = c;
                best_l = l;
            end
        end
        return {LW'(best_l), ACCW'(best)};
    endfunction

    task automatic do_reset();
        reset = 1'b1; go = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // go pulse, then feed N pairs at duty_pct valid rate; ends just after the last accept
    task automatic start_window(input int duty_pct, input bit poke_go);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        exp_q.push_back(model());
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || dbg_state !== 2'd1) begin
            n_errors++;
            $display("FAIL go_to_fill: busy=%0b in_ready=%0b state=%0d expected 1 1 1", busy, in_ready, dbg_state);
        end
        while (i < N && guard < 50*N) begin
            in_valid = ($urandom_range(99) < duty_pct);
            in_a = wa[i];
            in_b = wb[i];
            go = poke_go ? 1'($urandom_range(1)) : 1'b0;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0; go = 1'b0; in_a = '0; in_b = '0;
        n_checks++;
        if (i != N) begin
            n_errors++;
            $display("FAIL fill_count: accepted=%0d expected %0d", i, N);
        end
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_end: in_ready=%0b busy=%0b expected 0 1", in_ready, busy);
        end
    endtask

    // wait for done, check latency from last accept, pop scoreboard and compare
    task automatic wait_result(input string name, input bit poke_go);
        int  cyc = 0;
        bit  seen = 0;
        logic [W-1:0] e;
        while (cyc < LATENCY + 50 && !seen) begin
            go = (poke_go && cyc < 200) ? 1'($urandom_range(1)) : 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) seen = 1;
        end
        go = 1'b0;
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, LATENCY + 50);
            return;
        end
        n_checks++;
        if (cyc != LATENCY) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, cyc, LATENCY);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s_scoreboard: done with empty expected queue", name);
            return;
        end
        e = exp_q.pop_front();
        if ({lag, peak} !== e) begin
            n_errors++;
            $display("FAIL %s_result: lag=%0d peak=%0d expected lag=%0d peak=%0d", name,
                     $signed(lag), $signed(peak), $signed(e[W-1:ACCW]), $signed(e[ACCW-1:0]));
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || dbg_state !== 2'd0 || {lag, peak} !== e) begin
            n_errors++;
            $display("FAIL %s_hold: done=%0b state=%0d lag=%0d expected done=0 state=0 lag=%0d", name,
                     done, dbg_state, $signed(lag), $signed(e[W-1:ACCW]));
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || lag !== '0 || peak !== '0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset: in_ready=%0b done=%0b busy=%0b lag=%0d peak=%0d state=%0d expected all 0",
                     in_ready, done, busy, lag, peak, dbg_state);
        end
    endtask

    task automatic test_zero_lag();
        for (int i = 0; i < N; i++) begin
            wa[i] = DW'((i % 64) - 32);
            wb[i] = wa[i];
        end
        start_window(100, 1'b0);
        wait_result("zero_lag", 1'b0);
        n_checks++;
        if ($signed(lag) !== 6'sd0 || peak !== 36'd87424) begin
            n_errors++;
            $display("FAIL zero_lag_const: lag=%0d peak=%0d expected 0 87424", $signed(lag), peak);
        end
    endtask

    task automatic test_delay();
        for (int i = 0; i < N; i++) ra[i] = DW'($urandom_range(16383));
        for (int i = 0; i < N; i++) begin
            wa[i] = ra[i];
            wb[i] = (i < 5) ? '0 : ra[i-5];
        end
        start_window(100, 1'b0);
        wait_result("delay", 1'b0);
        n_checks++;
        if ($signed(lag) !== 6'sd5) begin
            n_errors++;
            $display("FAIL delay_lag: lag=%0d expected 5", $signed(lag));
        end
    endtask

    task automatic test_backpressure();
        // same data as the delayed-channel window, sparse valid, go poked in FILL and CORR
        start_window(30, 1'b1);
        wait_result("backpressure", 1'b1);
        n_checks++;
        if ($signed(lag) !== 6'sd5) begin
            n_errors++;
            $display("FAIL backpressure_lag: lag=%0d expected 5", $signed(lag));
        end
    endtask

    task automatic test_swap();
        for (int i = 0; i < N; i++) begin
            wb[i] = ra[i];
            wa[i] = (i < 5) ? '0 : ra[i-5];
        end
        start_window(100, 1'b0);
        wait_result("swap", 1'b0);
        n_checks++;
        if ($signed(lag) !== -6'sd5) begin
            n_errors++;
            $display("FAIL swap_lag: lag=%0d expected -5", $signed(lag));
        end
    endtask

    task automatic test_zeros();
        for (int i = 0; i < N; i++) begin
            wa[i] = '0;
            wb[i] = '0;
        end
        start_window(100, 1'b0);
        wait_result("zeros", 1'b0);
        n_checks++;
        if ($signed(lag) !== -6'sd16 || peak !== 36'd0) begin
            n_errors++;
            $display("FAIL zeros_tie: lag=%0d peak=%0d expected -16 0", $signed(lag), peak);
        end
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < N; i++) begin
            wa[i] = -14'sd8192;
            wb[i] = -14'sd8192;
        end
        start_window(100, 1'b0);
        wait_result("full_scale", 1'b0);
        n_checks++;
        if ($signed(lag) !== 6'sd0 || peak !== 36'd17179869184) begin
            n_errors++;
            $display("FAIL full_scale_const: lag=%0d peak=%0d expected 0 17179869184", $signed(lag), peak);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 0;
        for (int i = 0; i < N; i++) begin
            wa[i] = DW'((i % 64) - 32);
            wb[i] = wa[i];
        end
        start_window(100, 1'b0);
        repeat (4000) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        n_checks++;
        if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || lag !== '0 || peak !== '0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_mid: in_ready=%0b done=%0b busy=%0b lag=%0d peak=%0d state=%0d expected all 0",
                     in_ready, done, busy, lag, peak, dbg_state);
        end
        for (int c = 0; c < 4600; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin
            n_errors++;
            $display("FAIL reset_mid_no_done: done=1 seen expected 0");
        end
        // fresh window after the aborted one
        for (int i = 0; i < N; i++) begin
            wa[i] = ra[i];
            wb[i] = (i < 5) ? '0 : ra[i-5];
        end
        start_window(100, 1'b0);
        wait_result("after_reset", 1'b0);
        n_checks++;
        if ($signed(lag) !== 6'sd5) begin
            n_errors++;
            $display("FAIL after_reset_lag: lag=%0d expected 5", $signed(lag));
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        test_reset();
        test_zero_lag();
        test_delay();
        test_backpressure();
        test_swap();
        test_zeros();
        test_full_scale();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
